// File: rtl/cadence_blip_gen_pkg.sv
// Shared cadence definitions: FSM states, RPM width and phase-accumulator constants.
// Imported by the blip generator and the cadence calculator.
package cadence_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int unsigned RPM_W = 8;
  localparam int unsigned CNT_W = 16;

  // One crank revolution per minute worth of clock ticks: the accumulator modulus.
  function automatic longint unsigned full_of(input longint unsigned clk_hz);
    return clk_hz * 64'd60;
  endfunction

  function automatic longint unsigned half_of(input longint unsigned clk_hz);
    return full_of(clk_hz) / 64'd2;
  endfunction

endpackage

// File: rtl/cadence_blip_gen_if.sv
// Command handshake and emulated-sensor outputs of the cadence blip generator.
interface cadence_blip_gen_if;
  import cadence_pkg::*;

  logic [RPM_W-1:0] rpm_cmd;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             blips;
  logic             blip_strobe;
  logic [CNT_W-1:0] blip_count;
  logic             running;

  modport master (
    output rpm_cmd, cmd_valid,
    input  cmd_ready, blips, blip_strobe, blip_count, running
  );

  modport slave (
    input  rpm_cmd, cmd_valid,
    output cmd_ready, blips, blip_strobe, blip_count, running
  );

endinterface

// File: rtl/cadence_blip_gen.sv
// Phase-accumulator pedal-cadence pulse synthesiser: 50 % duty blips at a commanded RPM,
// continuous phase on rate change, and a stop that never truncates a high pulse.
module cadence_blip_gen
  import cadence_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned MAGNETS = 12,
  parameter int unsigned ACC_W   = 32
) (
  input  logic               clk50M,
  input  logic               reset,
  cadence_blip_gen_if.slave  bus
);

  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned STEP_W = 16;
  localparam logic [SUM_W-1:0] FULL = SUM_W'(full_of(64'(CLK_HZ)));
  localparam logic [SUM_W-1:0] HALF = SUM_W'(half_of(64'(CLK_HZ)));

  state_e           state_q, state_d;
  logic [RPM_W-1:0] rpm_q, rpm_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             blips_q, blips_d;
  logic             strobe_q, strobe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             running_q, running_d;

  logic [STEP_W-1:0] step_c;
  logic [SUM_W-1:0]  sum_c;
  logic [SUM_W-1:0]  acc_next_c;
  logic              wrap_c;
  logic              accept_c;

  // Phase step and modulo-FULL wrap; sum is one bit wider so acc + step cannot overflow.
  always_comb begin
    step_c     = STEP_W'(32'(rpm_q) * MAGNETS);
    sum_c      = SUM_W'(acc_q) + SUM_W'(step_c);
    wrap_c     = (sum_c >= FULL);
    acc_next_c = wrap_c ? (sum_c - FULL) : sum_c;
    accept_c   = bus.cmd_valid && ready_q;
  end

  always_comb begin
    state_d = state_q;
    rpm_d   = rpm_q;
    acc_d   = acc_q;
    blips_d = blips_q;

    case (state_q)
      IDLE: begin
        acc_d   = '0;
        blips_d = 1'b0;
        if (accept_c && (bus.rpm_cmd != '0)) begin
          rpm_d   = bus.rpm_cmd;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = ACC_W'(acc_next_c);
        blips_d = (acc_next_c >= HALF);
        if (accept_c) begin
          if (bus.rpm_cmd != '0) begin
            rpm_d = bus.rpm_cmd;
          end else if (!blips_q) begin
            state_d = IDLE;
            acc_d   = '0;
            blips_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Finish the current high phase at the old rate; the wrap is the falling edge.
        acc_d   = ACC_W'(acc_next_c);
        blips_d = (acc_next_c >= HALF);
        if (wrap_c) begin
          state_d = IDLE;
          acc_d   = '0;
          blips_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        blips_d = 1'b0;
      end
    endcase

    strobe_d  = blips_d && !blips_q;
    cnt_d     = cnt_q + CNT_W'(strobe_d);
    ready_d   = (state_d != DRAIN);
    running_d = (state_d != IDLE);
  end

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rpm_q     <= '0;
      acc_q     <= '0;
      blips_q   <= 1'b0;
      strobe_q  <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpm_q     <= rpm_d;
      acc_q     <= acc_d;
      blips_q   <= blips_d;
      strobe_q  <= strobe_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      running_q <= running_d;
    end
  end

  assign bus.cmd_ready   = ready_q;
  assign bus.blips       = blips_q;
  assign bus.blip_strobe = strobe_q;
  assign bus.blip_count  = cnt_q;
  assign bus.running     = running_q;

endmodule

// File: tb/tb_cadence_blip_gen.sv
// Directed bench for cadence_blip_gen at CLK_HZ=1000, MAGNETS=1 (FULL=60000, HALF=30000).
module tb_cadence_blip_gen;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cadence_blip_gen_if bus ();

  cadence_blip_gen #(
    .CLK_HZ (1000),
    .MAGNETS(1),
    .ACC_W  (32)
  ) dut (
    .clk50M(clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rise(input int budget, output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    while (edges < budget && !ok) begin
      step(1);
      edges++;
      if (bus.blip_strobe === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] rpm);
    bus.rpm_cmd   = rpm;
    bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.rpm_cmd = '0;
    bus.cmd_valid = 1'b0;
    step(2);
    checks++; if (bus.blips !== 1'b0) begin errors++; $display("FAIL reset_blips: got %b expected 0", bus.blips); end
    checks++; if (bus.blip_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", bus.blip_strobe); end
    checks++; if (bus.blip_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.blip_count); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", bus.running); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready); end
    rst = 1'b0;
    step(1);
    send(8'd0);
    step(2);
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL idle_zero_cmd_running: got %b expected 0", bus.running); end
    checks++; if (bus.blips !== 1'b0) begin errors++; $display("FAIL idle_zero_cmd_blips: got %b expected 0", bus.blips); end
  endtask

  task automatic test_start;
    send(8'd60);
    checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL start_running: got %b expected 1", bus.running); end
    step(499);
    checks++; if (bus.blips !== 1'b0) begin errors++; $display("FAIL start_e499_blips: got %b expected 0", bus.blips); end
    step(1);
    checks++; if (bus.blips !== 1'b1) begin errors++; $display("FAIL start_e500_blips: got %b expected 1", bus.blips); end
    checks++; if (bus.blip_strobe !== 1'b1) begin errors++; $display("FAIL start_e500_strobe: got %b expected 1", bus.blip_strobe); end
    checks++; if (bus.blip_count !== 16'd1) begin errors++; $display("FAIL start_e500_count: got %0d expected 1", bus.blip_count); end
    step(1);
    checks++; if (bus.blip_strobe !== 1'b0) begin errors++; $display("FAIL start_e501_strobe: got %b expected 0", bus.blip_strobe); end
    step(498);
    checks++; if (bus.blips !== 1'b1) begin errors++; $display("FAIL start_e999_blips: got %b expected 1", bus.blips); end
    step(1);
    checks++; if (bus.blips !== 1'b0) begin errors++; $display("FAIL start_e1000_blips: got %b expected 0", bus.blips); end
    step(500);
    checks++; if (bus.blips !== 1'b1) begin errors++; $display("FAIL start_e1500_blips: got %b expected 1", bus.blips); end
    checks++; if (bus.blip_count !== 16'd2) begin errors++; $display("FAIL start_e1500_count: got %0d expected 2", bus.blip_count); end
  endtask

  // At E2100 of the rpm-60 stream acc = 6000; switch to rpm 120 there.
  task automatic test_freq_change;
    step(600);
    send(8'd120);
    step(199);
    checks++; if (bus.blips !== 1'b0) begin errors++; $display("FAIL freq_pre_rise_blips: got %b expected 0", bus.blips); end
    step(1);
    checks++; if (bus.blip_strobe !== 1'b1) begin errors++; $display("FAIL freq_rise_strobe: got %b expected 1", bus.blip_strobe); end
    step(249);
    checks++; if (bus.blips !== 1'b1) begin errors++; $display("FAIL freq_high_end_blips: got %b expected 1", bus.blips); end
    step(1);
    checks++; if (bus.blips !== 1'b0) begin errors++; $display("FAIL freq_fall_blips: got %b expected 0", bus.blips); end
    step(249);
    checks++; if (bus.blips !== 1'b0) begin errors++; $display("FAIL freq_low_end_blips: got %b expected 0", bus.blips); end
    step(1);
    checks++; if (bus.blip_strobe !== 1'b1) begin errors++; $display("FAIL freq_rise2_strobe: got %b expected 1", bus.blip_strobe); end
    checks++; if (bus.blip_count !== 16'd4) begin errors++; $display("FAIL freq_count: got %0d expected 4", bus.blip_count); end
  endtask

  task automatic test_stop_low;
    step(250);
    checks++; if (bus.blips !== 1'b0) begin errors++; $display("FAIL stop_low_pre_blips: got %b expected 0", bus.blips); end
    send(8'd0);
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL stop_low_running: got %b expected 0", bus.running); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL stop_low_ready: got %b expected 1", bus.cmd_ready); end
    step(600);
    checks++; if (bus.blips !== 1'b0) begin errors++; $display("FAIL stop_low_idle_blips: got %b expected 0", bus.blips); end
    checks++; if (bus.blip_count !== 16'd4) begin errors++; $display("FAIL stop_low_count: got %0d expected 4", bus.blip_count); end
  endtask

  // Stop at acc 45000 (rpm 60): 250 edges of high remain; a DRAIN-time command must be ignored.
  task automatic test_stop_high;
    send(8'd60);
    step(750);
    checks++; if (bus.blips !== 1'b1) begin errors++; $display("FAIL stop_high_pre_blips: got %b expected 1", bus.blips); end
    send(8'd0);
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL stop_high_ready: got %b expected 0", bus.cmd_ready); end
    checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL stop_high_running: got %b expected 1", bus.running); end
    bus.rpm_cmd   = 8'd120;
    bus.cmd_valid = 1'b1;
    step(248);
    checks++; if (bus.blips !== 1'b1) begin errors++; $display("FAIL drain_e249_blips: got %b expected 1", bus.blips); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL drain_e249_ready: got %b expected 0", bus.cmd_ready); end
    bus.cmd_valid = 1'b0;
    step(1);
    checks++; if (bus.blips !== 1'b0) begin errors++; $display("FAIL drain_e250_blips: got %b expected 0", bus.blips); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL drain_e250_running: got %b expected 0", bus.running); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL drain_e250_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if (bus.blip_count !== 16'd5) begin errors++; $display("FAIL drain_count: got %0d expected 5", bus.blip_count); end
  endtask

  task automatic test_reset_mid;
    send(8'd60);
    step(500);
    checks++; if (bus.blip_strobe !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_strobe: got %b expected 1", bus.blip_strobe); end
    rst = 1'b1;
    #1;
    checks++; if (bus.blips !== 1'b0) begin errors++; $display("FAIL rst_mid_blips: got %b expected 0", bus.blips); end
    checks++; if (bus.blip_strobe !== 1'b0) begin errors++; $display("FAIL rst_mid_strobe: got %b expected 0", bus.blip_strobe); end
    checks++; if (bus.blip_count !== 16'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", bus.blip_count); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL rst_mid_running: got %b expected 0", bus.running); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", bus.cmd_ready); end
    step(2);
    rst = 1'b0;
    step(600);
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL rst_after_running: got %b expected 0", bus.running); end
    checks++; if (bus.blip_count !== 16'd0) begin errors++; $display("FAIL rst_after_count: got %0d expected 0", bus.blip_count); end
  endtask

  // rpm 7: first rise at k=ceil(30000/7)=4286; periods 8571/8572 summing to 60000 over 7.
  task automatic test_dither_wrap;
    int edges;
    int total;
    bit ok;
    total = 0;
    send(8'd7);
    wait_rise(5000, edges, ok);
    checks++; if (!ok || edges != 4286) begin errors++; $display("FAIL dither_first_rise: got %0d edges (seen=%b) expected 4286", edges, ok); end
    checks++; if (bus.blip_count !== 16'd1) begin errors++; $display("FAIL dither_first_count: got %0d expected 1", bus.blip_count); end
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    for (int i = 0; i < 7; i++) begin
      wait_rise(9000, edges, ok);
      total += edges;
      checks++; if (!ok || (edges != 8571 && edges != 8572)) begin errors++; $display("FAIL dither_period%0d: got %0d edges (seen=%b) expected 8571 or 8572", i, edges, ok); end
      if (i == 0) begin
        checks++; if (bus.blip_count !== 16'd0) begin errors++; $display("FAIL count_wrap: got %0d expected 0", bus.blip_count); end
      end
    end
    checks++; if (total != 60000) begin errors++; $display("FAIL dither_total: got %0d expected 60000", total); end
    checks++; if (bus.blip_count !== 16'd6) begin errors++; $display("FAIL dither_final_count: got %0d expected 6", bus.blip_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.rpm_cmd = '0;
    bus.cmd_valid = 1'b0;
    test_reset();
    test_start();
    test_freq_change();
    test_stop_low();
    test_stop_high();
    test_reset_mid();
    test_dither_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
